counter_sched_ctrl: RTL and testbench

Round-robin scheduler and sequencer for the shared counter datapath (ports en/clear/done, terminal count STOP).
- Up to NUM_REQ requesters each ask for one timed interval.
- The block grants one requester, clears the counter, enables it until done, then holds a completion indication until the granted requester acknowledges.
- Aborts, bad-done watchdog and fairness are handled here; the counter datapath stays a dumb counter.

---
 rtl/counter_sched_ctrl.sv | 151 +++++++++++++++
 tb/tb_counter_sched_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sched_ctrl.sv
// counter_sched_ctrl: round-robin scheduler/sequencer in front of a plain
// counter datapath. One requester at a time is granted an interval: the
// counter is cleared, enabled until it reports done (or a watchdog expires),
// then a completion is held until the granted requester acknowledges.
// A requester that drops its request while its interval runs aborts it.

module counter_sched_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int STOP    = 5,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id,
  output logic [NUM_REQ-1:0] cmpl,
  output logic               cnt_en,
  output logic               cnt_clear,
  input  logic               cnt_done,
  output logic               busy,
  output logic               err
);

  // A healthy interval takes STOP+1 enabled cycles; give two cycles of slack
  // before declaring the counter stuck.
  localparam int RUN_LIMIT = STOP + 3;
  localparam int RCW       = $clog2(RUN_LIMIT + 1);

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_WAIT_ACK,
    S_ABORT
  } state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [RCW-1:0]   run_cnt;

  logic             pick_valid;
  logic [IDW-1:0]   pick_id;
  logic             req_kept;
  logic             run_limit_hit;

  // Round-robin search: first set request strictly after the last served
  // requester, wrapping around; iterating from the far end lets the nearest
  // candidate win without a separate found flag.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_id    = IDW'(idx);
      end
    end
  end

  // Status of the granted requester and of the watchdog for the running interval.
  always_comb begin
    req_kept      = req[grant_id];
    run_limit_hit = (run_cnt == RCW'(RUN_LIMIT));
  end

  // Sequencer: every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      grant     <= '0;
      grant_id  <= '0;
      cmpl      <= '0;
      cnt_en    <= 1'b0;
      cnt_clear <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      ptr       <= IDW'(NUM_REQ - 1);
      run_cnt   <= '0;
    end else begin
      cnt_clear <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            state     <= S_CLR;
            grant     <= ONE_HOT0 << pick_id;
            grant_id  <= pick_id;
            err       <= 1'b0;
            cnt_clear <= 1'b1;
            busy      <= 1'b1;
          end
        end

        S_CLR: begin
          state   <= S_RUN;
          cnt_en  <= 1'b1;
          run_cnt <= RCW'(1);
        end

        S_RUN: begin
          if (!req_kept) begin
            state     <= S_ABORT;
            cnt_en    <= 1'b0;
            cnt_clear <= 1'b1;
            grant     <= '0;
          end else if (cnt_done || run_limit_hit) begin
            state  <= S_WAIT_ACK;
            cnt_en <= 1'b0;
            cmpl   <= grant;
            if (!cnt_done) begin
              err <= 1'b1;
            end
          end else begin
            run_cnt <= run_cnt + RCW'(1);
          end
        end

        S_ABORT: begin
          state <= S_IDLE;
          ptr   <= grant_id;
          busy  <= 1'b0;
        end

        S_WAIT_ACK: begin
          if (ack[grant_id]) begin
            state <= S_IDLE;
            grant <= '0;
            cmpl  <= '0;
            ptr   <= grant_id;
            busy  <= 1'b0;
          end
        end

        default: begin
          state     <= S_IDLE;
          grant     <= '0;
          cmpl      <= '0;
          cnt_en    <= 1'b0;
          cnt_clear <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sched_ctrl.sv
// Self-checking bench for counter_sched_ctrl with a behavioural counter
// datapath attached and a transaction-level reference model for random runs.

module tb_counter_sched_ctrl;

  localparam int NUM_REQ = 4;
  localparam int STOP    = 5;
  localparam int IDW     = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_REQ-1:0] req = '0;
  logic [NUM_REQ-1:0] ack = '0;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_id;
  logic [NUM_REQ-1:0] cmpl;
  logic               cnt_en;
  logic               cnt_clear;
  logic               cnt_done;
  logic               busy;
  logic               err;

  logic               stuck = 1'b0;
  int                 cnt = 0;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model of one granted job: owner (-1 = none), age in RUN cycles
  // (0 = clear cycle), and whether it is waiting for ack or aborting.
  int m_owner, m_age, m_last, m_gid;
  bit m_wait, m_abort, m_err;

  counter_sched_ctrl #(.NUM_REQ(NUM_REQ), .STOP(STOP), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .ack       (ack),
    .grant     (grant),
    .grant_id  (grant_id),
    .cmpl      (cmpl),
    .cnt_en    (cnt_en),
    .cnt_clear (cnt_clear),
    .cnt_done  (cnt_done),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Dumb counter datapath: clear wins, otherwise count while enabled.
  always @(posedge clk) begin
    if (cnt_clear) cnt <= 0;
    else if (cnt_en) cnt <= cnt + 1;
  end

  assign cnt_done = cnt_en && (cnt == STOP) && !stuck;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    ack   = '0;
    stuck = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    req   = 4'b1111;
    rst_n = 1'b0;
    tick();
    tick();
    obs = {grant, grant_id, cmpl, cnt_en, cnt_clear, busy, err};
    tests_run++;
    if (obs !== 14'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got %b expected %b", obs, 14'b0);
    end
    rst_n = 1'b1;
    req   = '0;
    tick();
  endtask

  task automatic test_single();
    logic [13:0] obs, exp;
    do_reset();
    req = 4'b0100;
    for (int c = 1; c <= 12; c++) begin
      tick();
      obs = {grant, grant_id, cmpl, cnt_en, cnt_clear, busy, err};
      exp = {((c >= 1 && c <= 10) ? 4'b0100 : 4'b0000), 2'd2,
             ((c >= 8 && c <= 10) ? 4'b0100 : 4'b0000),
             (c >= 2 && c <= 7), (c == 1), (c >= 1 && c <= 10), 1'b0};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("[TB] FAIL single c%0d: got %b expected %b", c, obs, exp);
      end
      if (c == 10) begin
        ack = 4'b0100;
        req = 4'b0000;
      end
      if (c == 11) ack = '0;
    end
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int n_grants = 0;
    int n_done = 0;
    int en_count = 0;
    int cmpl_age = 0;
    logic [NUM_REQ-1:0] prev_grant = '0;
    logic [NUM_REQ-1:0] one = 4'b0001;
    do_reset();
    req = 4'b1111;
    for (int cyc = 0; cyc < 200 && n_done < 5; cyc++) begin
      tick();
      if (grant != '0 && prev_grant == '0) begin
        if (n_grants < 5) begin
          tests_run++;
          if (grant_id !== IDW'(exp_order[n_grants])) begin
            tests_failed++;
            $display("[TB] FAIL rr_grant_id #%0d: got %0d expected %0d", n_grants, grant_id, exp_order[n_grants]);
          end
          tests_run++;
          if (grant !== (one << exp_order[n_grants])) begin
            tests_failed++;
            $display("[TB] FAIL rr_grant #%0d: got %b expected %b", n_grants, grant, one << exp_order[n_grants]);
          end
        end
        n_grants++;
        en_count = 0;
      end
      if (cnt_en) en_count++;
      if (cmpl != '0) begin
        cmpl_age++;
        if (cmpl_age == 1) begin
          tests_run++;
          if (en_count != STOP + 1) begin
            tests_failed++;
            $display("[TB] FAIL rr_en_cycles #%0d: got %0d expected %0d", n_done, en_count, STOP + 1);
          end
          n_done++;
        end
        if (cmpl_age == 2) ack = cmpl;
      end else begin
        cmpl_age = 0;
        ack = '0;
      end
      prev_grant = grant;
    end
    tests_run++;
    if (n_done < 5) begin
      tests_failed++;
      $display("[TB] FAIL rr_timeout: got %0d completions expected 5", n_done);
    end
  endtask

  task automatic test_abort();
    logic [13:0] obs, exp;
    logic [3:0] eg;
    logic [1:0] egid;
    do_reset();
    req = 4'b1010;
    for (int c = 1; c <= 7; c++) begin
      tick();
      eg   = (c <= 4) ? 4'b0010 : ((c == 7) ? 4'b1000 : 4'b0000);
      egid = (c == 7) ? 2'd3 : 2'd1;
      exp  = {eg, egid, 4'b0000, (c >= 2 && c <= 4),
              (c == 1 || c == 5 || c == 7), (c != 6), 1'b0};
      obs  = {grant, grant_id, cmpl, cnt_en, cnt_clear, busy, err};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("[TB] FAIL abort c%0d: got %b expected %b", c, obs, exp);
      end
      if (c == 4) req = 4'b1000;
    end
  endtask

  task automatic test_ack_filter();
    logic [13:0] obs, exp;
    logic [3:0] eg;
    do_reset();
    req = 4'b0010;
    for (int c = 1; c <= 11; c++) begin
      tick();
      eg  = (c <= 9) ? 4'b0010 : ((c == 11) ? 4'b0100 : 4'b0000);
      exp = {eg, ((c == 11) ? 2'd2 : 2'd1),
             ((c == 8 || c == 9) ? 4'b0010 : 4'b0000),
             (c >= 2 && c <= 7), (c == 1 || c == 11), (c != 10), 1'b0};
      obs = {grant, grant_id, cmpl, cnt_en, cnt_clear, busy, err};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("[TB] FAIL ack_filter c%0d: got %b expected %b", c, obs, exp);
      end
      if (c == 2)  req = 4'b0110;
      if (c == 8)  ack = 4'b0100;
      if (c == 9)  ack = 4'b0010;
      if (c == 10) ack = 4'b0000;
    end
  endtask

  task automatic test_watchdog();
    logic [13:0] obs, exp;
    logic [3:0] eg;
    do_reset();
    stuck = 1'b1;
    req   = 4'b0001;
    for (int c = 1; c <= 12; c++) begin
      tick();
      eg  = (c <= 10) ? 4'b0001 : ((c == 12) ? 4'b0010 : 4'b0000);
      exp = {eg, ((c == 12) ? 2'd1 : 2'd0),
             ((c == 10) ? 4'b0001 : 4'b0000),
             (c >= 2 && c <= 9), (c == 1 || c == 12), (c != 11),
             (c == 10 || c == 11)};
      obs = {grant, grant_id, cmpl, cnt_en, cnt_clear, busy, err};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("[TB] FAIL watchdog c%0d: got %b expected %b", c, obs, exp);
      end
      if (c == 10) begin
        ack = 4'b0001;
        req = 4'b0000;
      end
      if (c == 11) begin
        ack   = 4'b0000;
        req   = 4'b0010;
        stuck = 1'b0;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [13:0] obs, exp;
    do_reset();
    req = 4'b0001;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    obs = {grant, grant_id, cmpl, cnt_en, cnt_clear, busy, err};
    tests_run++;
    if (obs !== 14'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_immediate: got %b expected %b", obs, 14'b0);
    end
    tick();
    obs = {grant, grant_id, cmpl, cnt_en, cnt_clear, busy, err};
    tests_run++;
    if (obs !== 14'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_held: got %b expected %b", obs, 14'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1001;
    tick();
    obs = {grant, grant_id, cmpl, cnt_en, cnt_clear, busy, err};
    exp = {4'b0001, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_regrant: got %b expected %b", obs, exp);
    end
  endtask

  // Advance the reference model by one clock edge given the inputs seen before it.
  task automatic model_step(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] a, input logic d);
    if (m_owner < 0) begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        int idx;
        idx = (m_last + k) % NUM_REQ;
        if (r[idx]) m_owner = idx;
      end
      if (m_owner >= 0) begin
        m_age   = 0;
        m_wait  = 1'b0;
        m_abort = 1'b0;
        m_err   = 1'b0;
        m_gid   = m_owner;
      end
    end else if (m_abort) begin
      m_last  = m_owner;
      m_owner = -1;
      m_abort = 1'b0;
    end else if (m_wait) begin
      if (a[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
        m_wait  = 1'b0;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (!r[m_owner]) begin
      m_abort = 1'b1;
    end else if (d) begin
      m_wait = 1'b1;
    end else if (m_age == STOP + 3) begin
      m_wait = 1'b1;
      m_err  = 1'b1;
    end else begin
      m_age++;
    end
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] r_s, a_s;
    logic d_s;
    logic [13:0] obs, exp;
    logic [NUM_REQ-1:0] one = 4'b0001;
    logic [NUM_REQ-1:0] eg, ec;
    logic ee, eclr, eb;
    int n_grants = 0;
    do_reset();
    m_owner = -1;
    m_last  = NUM_REQ - 1;
    m_gid   = 0;
    m_age   = 0;
    m_wait  = 1'b0;
    m_abort = 1'b0;
    m_err   = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        ack[i] = ($urandom_range(0, 7) == 0);
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        end else if (cmpl[i]) begin
          ack[i] = ($urandom_range(0, 1) == 0);
          if (ack[i] && $urandom_range(0, 2) != 0) req[i] = 1'b0;
        end else if (grant[i] && cnt_en) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else if (!grant[i]) begin
          if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
        end
      end
      if (!busy && $urandom_range(0, 9) == 0) stuck = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      r_s = req;
      a_s = ack;
      d_s = cnt_done;
      tick();
      model_step(r_s, a_s, d_s);
      eg   = (m_owner >= 0 && !m_abort) ? (one << m_owner) : '0;
      ec   = (m_owner >= 0 && m_wait) ? (one << m_owner) : '0;
      ee   = (m_owner >= 0) && !m_abort && !m_wait && (m_age >= 1);
      eclr = (m_owner >= 0) && (m_abort || (!m_wait && m_age == 0));
      eb   = (m_owner >= 0);
      exp  = {eg, IDW'(m_gid), ec, ee, eclr, eb, m_err};
      obs  = {grant, grant_id, cmpl, cnt_en, cnt_clear, busy, err};
      if (eclr && !m_abort) n_grants++;
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("[TB] FAIL random cyc%0d: got %b expected %b", cyc, obs, exp);
      end
    end
    tests_run++;
    if (n_grants < 20) begin
      tests_failed++;
      $display("[TB] FAIL random_activity: got %0d grants expected at least 20", n_grants);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_ack_filter();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
